// File: rtl/mul_seq_controller.sv
// Sequential shift-add unsigned multiplier controller that stalls the pipeline while a multiply is in flight.
// Optional EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mul_seq_controller #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               flush,
   input  logic [WIDTH-1:0]   srcA,
   input  logic [WIDTH-1:0]   srcB,
   output logic               busy,
   output logic               stall,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    mcand_next;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    acc_next;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] mplier_next;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             run_last;

   // Next-state, datapath step and the combinational stall request
   always_comb begin
      state_next  = state;
      mcand_next  = mcand;
      mplier_next = mplier;
      acc_next    = acc;
      count_next  = count;
      stall       = 1'b0;
      run_last    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !flush) begin
               stall       = 1'b1;
               state_next  = S_RUN;
               mcand_next  = PW'(srcA);
               mplier_next = srcB;
               acc_next    = '0;
               count_next  = CW'(WIDTH);
            end
         end
         S_RUN: begin
            stall = 1'b1;
            if (mplier[0]) begin
               acc_next = acc + mcand;
            end
            mcand_next  = mcand << 1;
            mplier_next = mplier >> 1;
            count_next  = count - CW'(1);
`ifdef EARLY_TERM_EN
            run_last = (count == CW'(1)) || (mplier_next == '0);
`else
            run_last = (count == CW'(1));
`endif
            if (flush) begin
               state_next = S_IDLE;
            end else if (run_last) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; result commits as DONE is entered
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_next;
         mcand  <= mcand_next;
         mplier <= mplier_next;
         acc    <= acc_next;
         count  <= count_next;
         busy   <= (state_next == S_RUN);
         done   <= (state_next == S_DONE);
         if (state_next == S_DONE) begin
            result <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_mul_seq_controller.sv
// Self-checking bench for mul_seq_controller: per-cycle stall/busy/done timelines and products
// compared against a timeline-and-arithmetic reference model, directed and randomized.
module tb_mul_seq_controller;

   localparam int unsigned W  = 32;
   localparam int unsigned NT = 40;
`ifdef EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic           clk;
   logic           reset;
   logic           start;
   logic           flush;
   logic [W-1:0]   srcA;
   logic [W-1:0]   srcB;
   logic           busy;
   logic           stall;
   logic           done;
   logic [2*W-1:0] result;

   int             n_checks = 0;
   int             n_errors = 0;
   logic [2*W-1:0] exp_result;

   mul_seq_controller #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .flush  (flush),
      .srcA   (srcA),
      .srcB   (srcB),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of RUN cycles the reference expects for a given multiplier
   function automatic int exp_len(input logic [W-1:0] b);
      int n;
      n = 1;
      for (int i = 0; i < int'(W); i++) begin
         if (b[i]) n = i + 1;
      end
      return EARLY ? n : int'(W);
   endfunction

   // Expected timelines: cycle 0 is the request cycle; f<0 no flush, f==0 flush with start, f>0 flush in RUN cycle f
   function automatic void exp_tr(input int len, input int f,
                                  output logic [NT-1:0] st, output logic [NT-1:0] bz,
                                  output logic [NT-1:0] dn);
      int last;
      st = '0;
      bz = '0;
      dn = '0;
      if (f == 0) return;
      last = (f > 0) ? f : len;
      for (int c = 0; c <= last; c++) st[c] = 1'b1;
      for (int c = 1; c <= last; c++) bz[c] = 1'b1;
      if (f < 0) dn[len + 1] = 1'b1;
   endfunction

   // Issues one request and records the observed outputs over a fixed window
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int f, input bit hold,
                         output logic [NT-1:0] st, output logic [NT-1:0] bz,
                         output logic [NT-1:0] dn, output logic [2*W-1:0] res);
      int len;
      len = exp_len(b);
      @(posedge clk);
      #1;
      srcA  = a;
      srcB  = b;
      start = 1'b1;
      flush = (f == 0);
      for (int c = 0; c < int'(NT); c++) begin
         @(negedge clk);
         st[c] = stall;
         bz[c] = busy;
         dn[c] = done;
         @(posedge clk);
         #1;
         if ((c + 1) <= len && (f < 0 || (c + 1) <= f))
            start = hold ? 1'b1 : 1'($urandom);
         else
            start = 1'b0;
         flush = ((c + 1) == f);
      end
      start = 1'b0;
      flush = 1'b0;
      res   = result;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      srcA  = '0;
      srcB  = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b expected 0", done); end
      n_checks++;
      if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b expected 0", stall); end
      n_checks++;
      if (result !== '0) begin n_errors++; $display("FAIL reset_result got %h expected 0", result); end
      exp_result = '0;
   endtask

   task automatic test_basic;
      logic [NT-1:0] st, bz, dn, es, eb, ed;
      logic [2*W-1:0] res;
      run_op(32'd7, 32'd6, -1, 1'b1, st, bz, dn, res);
      exp_tr(exp_len(32'd6), -1, es, eb, ed);
      exp_result = 64'd42;
      n_checks++;
      if (st !== es) begin n_errors++; $display("FAIL basic_stall got %h expected %h", st, es); end
      n_checks++;
      if (bz !== eb) begin n_errors++; $display("FAIL basic_busy got %h expected %h", bz, eb); end
      n_checks++;
      if (dn !== ed) begin n_errors++; $display("FAIL basic_done got %h expected %h", dn, ed); end
      n_checks++;
      if (res !== exp_result) begin n_errors++; $display("FAIL basic_result got %h expected %h", res, exp_result); end
   endtask

   task automatic test_flush;
      logic [NT-1:0] st, bz, dn, es, eb, ed;
      logic [2*W-1:0] res;
      int len, f;
      len = exp_len(32'd5);
      f   = (len >= 10) ? 10 : len;
      run_op(32'd3, 32'd5, f, 1'b1, st, bz, dn, res);
      exp_tr(len, f, es, eb, ed);
      n_checks++;
      if (st !== es) begin n_errors++; $display("FAIL flush_stall got %h expected %h", st, es); end
      n_checks++;
      if (bz !== eb) begin n_errors++; $display("FAIL flush_busy got %h expected %h", bz, eb); end
      n_checks++;
      if (dn !== '0) begin n_errors++; $display("FAIL flush_done got %h expected 0", dn); end
      n_checks++;
      if (res !== 64'd42) begin n_errors++; $display("FAIL flush_result got %h expected %h", res, 64'd42); end
   endtask

   task automatic test_all_ones;
      logic [NT-1:0] st, bz, dn, ed;
      logic [2*W-1:0] res;
      run_op('1, '1, -1, 1'b0, st, bz, dn, res);
      ed = NT'(1) << 33;
      exp_result = 64'hFFFF_FFFE_0000_0001;
      n_checks++;
      if (dn !== ed) begin n_errors++; $display("FAIL ones_done got %h expected %h", dn, ed); end
      n_checks++;
      if (res !== exp_result) begin n_errors++; $display("FAIL ones_result got %h expected %h", res, exp_result); end
   endtask

   task automatic test_start_with_flush;
      logic [NT-1:0] st, bz, dn;
      logic [2*W-1:0] res;
      run_op(32'd11, 32'd13, 0, 1'b0, st, bz, dn, res);
      n_checks++;
      if (bz !== '0) begin n_errors++; $display("FAIL sflush_busy got %h expected 0", bz); end
      n_checks++;
      if (st !== '0) begin n_errors++; $display("FAIL sflush_stall got %h expected 0", st); end
      n_checks++;
      if (res !== exp_result) begin n_errors++; $display("FAIL sflush_result got %h expected %h", res, exp_result); end
   endtask

   task automatic test_early;
      logic [NT-1:0] st, bz, dn, ed;
      logic [2*W-1:0] res;
      run_op(32'd3, 32'd5, -1, 1'b1, st, bz, dn, res);
      ed = NT'(1) << (EARLY ? 4 : 33);
      n_checks++;
      if (dn !== ed) begin n_errors++; $display("FAIL early35_done got %h expected %h", dn, ed); end
      n_checks++;
      if (res !== 64'd15) begin n_errors++; $display("FAIL early35_result got %h expected 15", res); end
      run_op(32'd9, 32'd0, -1, 1'b1, st, bz, dn, res);
      ed = NT'(1) << (EARLY ? 2 : 33);
      exp_result = '0;
      n_checks++;
      if (dn !== ed) begin n_errors++; $display("FAIL early90_done got %h expected %h", dn, ed); end
      n_checks++;
      if (res !== '0) begin n_errors++; $display("FAIL early90_result got %h expected 0", res); end
   endtask

   task automatic test_reset_mid;
      @(posedge clk);
      #1;
      srcA  = 32'h1234_5678;
      srcB  = 32'hFFFF_FFFF;
      start = 1'b1;
      flush = 1'b1;
      #0 flush = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      reset = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      exp_result = '0;
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy got %b expected 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_errors++; $display("FAIL rmid_done got %b expected 0", done); end
      n_checks++;
      if (stall !== 1'b0) begin n_errors++; $display("FAIL rmid_stall got %b expected 0", stall); end
      n_checks++;
      if (result !== '0) begin n_errors++; $display("FAIL rmid_result got %h expected 0", result); end
   endtask

   task automatic test_random;
      logic [NT-1:0] st, bz, dn, es, eb, ed;
      logic [2*W-1:0] res;
      logic [W-1:0] a, b;
      int len, f;
      for (int i = 0; i < 25; i++) begin
         a   = $urandom;
         b   = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 255));
         len = exp_len(b);
         f   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
         run_op(a, b, f, 1'($urandom), st, bz, dn, res);
         exp_tr(len, f, es, eb, ed);
         if (f < 0) exp_result = 64'(a) * 64'(b);
         n_checks++;
         if (st !== es) begin n_errors++; $display("FAIL rnd%0d_stall got %h expected %h", i, st, es); end
         n_checks++;
         if (bz !== eb) begin n_errors++; $display("FAIL rnd%0d_busy got %h expected %h", i, bz, eb); end
         n_checks++;
         if (dn !== ed) begin n_errors++; $display("FAIL rnd%0d_done got %h expected %h", i, dn, ed); end
         n_checks++;
         if (res !== exp_result) begin n_errors++; $display("FAIL rnd%0d_result got %h expected %h", i, res, exp_result); end
      end
   endtask

   // Requester holds start through DONE and immediately issues the next multiply
   task automatic test_back_to_back;
      logic [W-1:0] a1, b1, a2, b2;
      logic [2*W-1:0] r1, r2;
      logic st_d;
      int l1, l2, d1, d2;
      a1 = $urandom;
      b1 = W'($urandom_range(1, 4000));
      a2 = $urandom;
      b2 = $urandom;
      l1 = exp_len(b1);
      l2 = exp_len(b2);
      d1 = -1;
      d2 = -1;
      r1 = '0;
      r2 = '0;
      st_d = 1'b1;
      @(posedge clk);
      #1;
      srcA  = a1;
      srcB  = b1;
      start = 1'b1;
      flush = 1'b0;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         if (done) begin
            if (d1 < 0) begin
               d1 = c; r1 = result; st_d = stall;
            end else if (d2 < 0) begin
               d2 = c; r2 = result;
            end
         end
         @(posedge clk);
         #1;
         if (d1 >= 0 && c == d1) begin
            srcA = a2;
            srcB = b2;
         end
         if (d2 >= 0) start = 1'b0;
      end
      start = 1'b0;
      exp_result = 64'(a2) * 64'(b2);
      n_checks++;
      if (d1 != l1 + 1) begin n_errors++; $display("FAIL b2b_done1 got cycle %0d expected %0d", d1, l1 + 1); end
      n_checks++;
      if (r1 !== 64'(a1) * 64'(b1)) begin n_errors++; $display("FAIL b2b_result1 got %h expected %h", r1, 64'(a1) * 64'(b1)); end
      n_checks++;
      if (st_d !== 1'b0) begin n_errors++; $display("FAIL b2b_stall_done got %b expected 0", st_d); end
      n_checks++;
      if (d2 != l1 + l2 + 3) begin n_errors++; $display("FAIL b2b_done2 got cycle %0d expected %0d", d2, l1 + l2 + 3); end
      n_checks++;
      if (r2 !== exp_result) begin n_errors++; $display("FAIL b2b_result2 got %h expected %h", r2, exp_result); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flush();
      test_all_ones();
      test_start_with_flush();
      test_early();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
